tr_mode_sel: RTL and testbench

Registered AUTO/MANUAL source selector for the stepper-driver TX path. It sits between the AUTO and MANUAL command generators and the step-pulse generator/driver. It forwards period, direction, drive-enable and counter-enable from the source picked by `cheak`. Unlike a plain mux, it enforces a programmable dead-time (driver disabled) on every mode switch and on every direction reversal while driving, and it clamps the period to a minimum value.

---
 rtl/tr_mode_sel_if.sv | 34 +++
 rtl/tr_mode_sel.sv | 163 ++++++++++++++++
 tb/tb_tr_mode_sel.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/tr_mode_sel_if.sv
// Command/status bundle between the AUTO/MANUAL command generators and the
// TX-path source selector. The selector connects through the slave modport.
interface tr_mode_sel_if #(
  parameter int WIDTH_TR = 16,
  parameter int DEAD_W   = 8
);
  logic                cheak;
  logic                dir_AUTO;
  logic                dir_MANUAL;
  logic                enable_AUTO;
  logic                pulse_enable;
  logic                count_MANUAL;
  logic [WIDTH_TR-1:0] period_AUTO;
  logic [WIDTH_TR-1:0] period_MANUAL;
  logic [DEAD_W-1:0]   dead_time;
  logic                drv_en_TR;
  logic                dir_TR;
  logic                counter_en_TR;
  logic [WIDTH_TR-1:0] period_TR;
  logic                busy_TR;
  logic                mode_TR;

  modport master (
    output cheak, dir_AUTO, dir_MANUAL, enable_AUTO, pulse_enable, count_MANUAL,
    output period_AUTO, period_MANUAL, dead_time,
    input  drv_en_TR, dir_TR, counter_en_TR, period_TR, busy_TR, mode_TR
  );

  modport slave (
    input  cheak, dir_AUTO, dir_MANUAL, enable_AUTO, pulse_enable, count_MANUAL,
    input  period_AUTO, period_MANUAL, dead_time,
    output drv_en_TR, dir_TR, counter_en_TR, period_TR, busy_TR, mode_TR
  );
endinterface

// File: rtl/tr_mode_sel.sv
// Registered AUTO/MANUAL source selector for the stepper TX path. Inserts a
// driver-off dead-time on every mode switch and on direction reversal while driving.
module tr_mode_sel #(
  parameter int                  WIDTH_TR   = 16,
  parameter int                  DEAD_W     = 8,
  parameter logic [WIDTH_TR-1:0] PERIOD_MIN = 16'd10
) (
  input  logic         clk,
  input  logic         rst,
  tr_mode_sel_if.slave bus
);

  typedef enum logic [1:0] {
    RUN_A = 2'd0,
    RUN_M = 2'd1,
    DEAD  = 2'd2
  } state_e;

  localparam logic [WIDTH_TR-1:0] PERIOD_ZERO = {WIDTH_TR{1'b0}};
  localparam logic [DEAD_W-1:0]   DEAD_ZERO   = {DEAD_W{1'b0}};
  localparam logic [DEAD_W-1:0]   DEAD_ONE    = {{(DEAD_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH_TR-1:0] clamp_period(input logic [WIDTH_TR-1:0] p);
    logic [WIDTH_TR-1:0] r;
    if (p == PERIOD_ZERO) begin
      r = PERIOD_ZERO;
    end else if (p < PERIOD_MIN) begin
      r = PERIOD_MIN;
    end else begin
      r = p;
    end
    return r;
  endfunction

  function automatic logic [DEAD_W-1:0] dead_len(input logic [DEAD_W-1:0] dt);
    return (dt == DEAD_ZERO) ? DEAD_ONE : dt;
  endfunction

  state_e              state_q, state_d;
  logic [DEAD_W-1:0]   cnt_q, cnt_d;
  logic [DEAD_W-1:0]   dead_n_q, dead_n_d;
  logic                samp_pend_q, samp_pend_d;
  logic                drv_en_q, drv_en_d;
  logic                dir_q, dir_d;
  logic                counter_en_q, counter_en_d;
  logic [WIDTH_TR-1:0] period_q, period_d;
  logic                busy_q, busy_d;
  logic                mode_q, mode_d;

  logic                src_auto;
  logic                src_dir;
  logic                src_en;
  logic [WIDTH_TR-1:0] src_period;
  logic                trigger;
  logic [DEAD_W-1:0]   dead_eff;
  logic                dead_done;

  // Source select and dead-time bookkeeping; in DEAD the exit source follows cheak.
  always_comb begin
    src_auto   = (state_q == DEAD) ? bus.cheak : (state_q == RUN_A);
    src_dir    = src_auto ? bus.dir_AUTO    : bus.dir_MANUAL;
    src_en     = src_auto ? bus.enable_AUTO : bus.pulse_enable;
    src_period = src_auto ? bus.period_AUTO : bus.period_MANUAL;
    trigger    = (bus.cheak != src_auto) || (drv_en_q && (src_dir != dir_q));
    // After reset the length is taken from the first cycle out of reset.
    dead_eff   = samp_pend_q ? dead_len(bus.dead_time) : dead_n_q;
    dead_done  = (cnt_q == (dead_eff - DEAD_ONE));
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dead_n_d    = dead_n_q;
    samp_pend_d = samp_pend_q;
    case (state_q)
      RUN_A, RUN_M: begin
        if (trigger) begin
          state_d  = DEAD;
          cnt_d    = DEAD_ZERO;
          dead_n_d = dead_len(bus.dead_time);
        end else begin
          state_d  = state_q;
        end
      end
      DEAD: begin
        samp_pend_d = 1'b0;
        dead_n_d    = dead_eff;
        if (dead_done) begin
          state_d = bus.cheak ? RUN_A : RUN_M;
          cnt_d   = DEAD_ZERO;
        end else begin
          cnt_d   = cnt_q + DEAD_ONE;
        end
      end
      default: begin
        state_d     = DEAD;
        cnt_d       = DEAD_ZERO;
        samp_pend_d = 1'b1;
      end
    endcase
  end

  // Output logic: load the clamped source when the next state is a RUN state.
  always_comb begin
    drv_en_d     = drv_en_q;
    dir_d        = dir_q;
    counter_en_d = counter_en_q;
    period_d     = period_q;
    busy_d       = busy_q;
    mode_d       = mode_q;
    case (state_d)
      RUN_A, RUN_M: begin
        drv_en_d     = src_en && (src_period != PERIOD_ZERO);
        dir_d        = src_dir;
        counter_en_d = src_auto ? 1'b0 : bus.count_MANUAL;
        period_d     = clamp_period(src_period);
        busy_d       = 1'b0;
        mode_d       = src_auto;
      end
      default: begin
        drv_en_d     = 1'b0;
        counter_en_d = 1'b0;
        busy_d       = 1'b1;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DEAD;
      cnt_q        <= DEAD_ZERO;
      dead_n_q     <= DEAD_ONE;
      samp_pend_q  <= 1'b1;
      drv_en_q     <= 1'b0;
      dir_q        <= 1'b0;
      counter_en_q <= 1'b0;
      period_q     <= PERIOD_ZERO;
      busy_q       <= 1'b1;
      mode_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dead_n_q     <= dead_n_d;
      samp_pend_q  <= samp_pend_d;
      drv_en_q     <= drv_en_d;
      dir_q        <= dir_d;
      counter_en_q <= counter_en_d;
      period_q     <= period_d;
      busy_q       <= busy_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.drv_en_TR     = drv_en_q;
  assign bus.dir_TR        = dir_q;
  assign bus.counter_en_TR = counter_en_q;
  assign bus.period_TR     = period_q;
  assign bus.busy_TR       = busy_q;
  assign bus.mode_TR       = mode_q;

endmodule

// File: tb/tb_tr_mode_sel.sv
// Scoreboard bench for tr_mode_sel: a countdown-based reference model pushes the
// expected outputs for every clock edge; a monitor pops and compares them.
module tb_tr_mode_sel;

  typedef struct packed {
    logic        drv;
    logic        dir;
    logic        cnt;
    logic [15:0] per;
    logic        busy;
    logic        mode;
  } out_t;

  logic clk = 1'b0;
  logic rst;

  tr_mode_sel_if #(.WIDTH_TR(16), .DEAD_W(8)) bus ();

  tr_mode_sel #(.WIDTH_TR(16), .DEAD_W(8), .PERIOD_MIN(16'd10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: running flag, current mode and remaining busy cycles.
  bit   m_run  = 1'b0;
  bit   m_pend = 1'b1;
  bit   m_mode = 1'b0;
  int   m_left = 0;
  out_t m_out  = '0;

  function automatic out_t load_src(input bit auto_m, input out_t cur);
    out_t        o;
    logic [15:0] p;
    o      = cur;
    p      = auto_m ? bus.period_AUTO : bus.period_MANUAL;
    o.per  = (p == 16'd0) ? 16'd0 : ((p < 16'd10) ? 16'd10 : p);
    o.drv  = (auto_m ? bus.enable_AUTO : bus.pulse_enable) && (p != 16'd0);
    o.dir  = auto_m ? bus.dir_AUTO : bus.dir_MANUAL;
    o.cnt  = auto_m ? 1'b0 : bus.count_MANUAL;
    o.mode = auto_m;
    o.busy = 1'b0;
    return o;
  endfunction

  task automatic model_step();
    int n;
    bit sdir;
    n = (bus.dead_time == 8'd0) ? 1 : int'(bus.dead_time);
    if (rst) begin
      m_run  = 1'b0;
      m_pend = 1'b1;
      m_left = 0;
      m_out  = '0;
      m_out.busy = 1'b1;
    end else if (!m_run) begin
      if (m_pend) begin
        m_pend = 1'b0;
        m_left = n - 1;
      end
      if (m_left == 0) begin
        m_run  = 1'b1;
        m_mode = bus.cheak;
        m_out  = load_src(m_mode, m_out);
      end else begin
        m_left    = m_left - 1;
        m_out.drv = 1'b0;
        m_out.cnt = 1'b0;
        m_out.busy = 1'b1;
      end
    end else begin
      sdir = m_mode ? bus.dir_AUTO : bus.dir_MANUAL;
      if ((bus.cheak != m_mode) || (m_out.drv && (sdir != m_out.dir))) begin
        m_run      = 1'b0;
        m_left     = n - 1;
        m_out.drv  = 1'b0;
        m_out.cnt  = 1'b0;
        m_out.busy = 1'b1;
      end else begin
        m_out = load_src(m_mode, m_out);
      end
    end
    exp_q.push_back(m_out);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: each entry describes the outputs after the edge following its push.
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        a = {bus.drv_en_TR, bus.dir_TR, bus.counter_en_TR, bus.period_TR,
             bus.busy_TR, bus.mode_TR};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got drv=%0b dir=%0b cnt=%0b per=%0d busy=%0b mode=%0b, expected drv=%0b dir=%0b cnt=%0b per=%0d busy=%0b mode=%0b",
                   $time, a.drv, a.dir, a.cnt, a.per, a.busy, a.mode,
                   e.drv, e.dir, e.cnt, e.per, e.busy, e.mode);
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    bus.cheak         = 1'b1;
    bus.dead_time     = 8'd4;
    bus.period_AUTO   = 16'd200;
    bus.enable_AUTO   = 1'b1;
    bus.dir_AUTO      = 1'b1;
    bus.dir_MANUAL    = 1'b0;
    bus.pulse_enable  = 1'b0;
    bus.count_MANUAL  = 1'b0;
    bus.period_MANUAL = 16'd0;
    cyc(3);
    rst = 1'b0;
    cyc(7);

    bus.pulse_enable  = 1'b1;
    bus.count_MANUAL  = 1'b1;
    bus.period_MANUAL = 16'd50;
    bus.cheak         = 1'b0;
    cyc(7);

    bus.dir_MANUAL = 1'b1;
    cyc(7);
    bus.pulse_enable = 1'b0;
    cyc(2);
    bus.dir_MANUAL = 1'b0;
    cyc(2);
    bus.dir_MANUAL = 1'b1;
    cyc(2);

    bus.cheak = 1'b1;
    cyc(6);
    bus.period_AUTO = 16'd3;
    cyc(2);
    bus.period_AUTO = 16'd0;
    cyc(2);
    bus.period_AUTO = 16'd10;
    cyc(2);

    bus.dead_time = 8'd0;
    bus.cheak     = 1'b0;
    cyc(3);
    bus.dead_time = 8'd4;

    bus.cheak = 1'b1;
    cyc(1);
    bus.cheak = 1'b0;
    cyc(1);
    bus.cheak = 1'b1;
    cyc(6);

    bus.cheak = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(7);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(19, 0) == 0) bus.cheak = ~bus.cheak;
      if ($urandom_range(7, 0) == 0) bus.dir_AUTO = ~bus.dir_AUTO;
      if ($urandom_range(7, 0) == 0) bus.dir_MANUAL = ~bus.dir_MANUAL;
      if ($urandom_range(9, 0) == 0) bus.enable_AUTO = ~bus.enable_AUTO;
      if ($urandom_range(9, 0) == 0) bus.pulse_enable = ~bus.pulse_enable;
      if ($urandom_range(5, 0) == 0) bus.count_MANUAL = ~bus.count_MANUAL;
      if ($urandom_range(5, 0) == 0) begin
        case ($urandom_range(3, 0))
          0:       bus.period_AUTO = 16'd0;
          1:       bus.period_AUTO = 16'($urandom_range(15, 1));
          default: bus.period_AUTO = 16'($urandom_range(65535, 16));
        endcase
      end
      if ($urandom_range(5, 0) == 0) begin
        case ($urandom_range(3, 0))
          0:       bus.period_MANUAL = 16'd0;
          1:       bus.period_MANUAL = 16'($urandom_range(15, 1));
          default: bus.period_MANUAL = 16'($urandom_range(65535, 16));
        endcase
      end
      bus.dead_time = 8'($urandom_range(5, 0));
      rst = ($urandom_range(149, 0) == 0);
      cyc(1);
    end

    rst = 1'b0;
    cyc(3);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 1", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
